// File: rtl/mult_accum_seq_if.sv
// Burst handshake, operand stream and result bundle between a burst
// requester (master) and the mult_accum sequencer (slave).
interface mult_accum_seq_if #(
    parameter int LEN_W = 5
) ();
    logic             seq_start;
    logic             seq_ready;
    logic [LEN_W-1:0] seq_len;
    logic             seq_clear;
    logic             seq_subtract;
    logic             seq_abort;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             result_valid;
    logic [31:0]      result_data;
    logic             busy;

    modport master (
        output seq_start, seq_len, seq_clear, seq_subtract, seq_abort,
        output op_valid, op_a, op_b,
        input  seq_ready, op_ready, result_valid, result_data, busy
    );

    modport slave (
        input  seq_start, seq_len, seq_clear, seq_subtract, seq_abort,
        input  op_valid, op_a, op_b,
        output seq_ready, op_ready, result_valid, result_data, busy
    );
endinterface

// File: rtl/mult_accum_seq.sv
// Sequencer/arbiter in front of the 16x16 signed MAC: runs dot-product bursts
// and merges single-cycle CPU accumulate/reset strobes, deferring them while busy.
module mult_accum_seq #(
    parameter int LEN_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic [15:0] cpu_b,
    input  logic        cpu_mult_enabled,
    input  logic        cpu_add_or_sub,
    input  logic        cpu_reset_accum,
    input  logic        cpu_accumulate,
    mult_accum_seq_if.slave bus,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic        mac_mult_enabled,
    output logic        mac_reset_accum,
    output logic        mac_accumulate,
    output logic        mac_add_or_sub,
    input  logic [31:0] mac_result
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             sub_q, sub_d;
    logic             pend_reset_q, pend_reset_d;
    logic             pend_accum_q, pend_accum_d;
    logic [31:0]      result_q, result_d;

    logic pending_s, idle_free_s, accept_s;
    logic svc_reset_s, svc_accum_s, pr_after_s, pa_after_s;
    logic seq_ready_s, op_ready_s, result_valid_s, busy_s;
    logic [31:0] result_data_s;

    assign pending_s   = pend_reset_q | pend_accum_q;
    assign idle_free_s = (state_q == ST_IDLE) & ~pending_s;
    assign accept_s    = bus.seq_start & idle_free_s;
    // Deferred strobes drain one per IDLE cycle, reset first.
    assign svc_reset_s = (state_q == ST_IDLE) & pend_reset_q;
    assign svc_accum_s = (state_q == ST_IDLE) & ~pend_reset_q & pend_accum_q;
    assign pr_after_s  = pend_reset_q & ~svc_reset_s;
    assign pa_after_s  = pend_accum_q & ~svc_accum_s;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= LEN_ZERO;
            sub_q        <= 1'b0;
            pend_reset_q <= 1'b0;
            pend_accum_q <= 1'b0;
            result_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            sub_q        <= sub_d;
            pend_reset_q <= pend_reset_d;
            pend_accum_q <= pend_accum_d;
            result_q     <= result_d;
        end
    end

    // Next-state, term counter and result capture
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        sub_d    = sub_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    remain_d = bus.seq_len;
                    sub_d    = bus.seq_subtract;
                    if (bus.seq_len == LEN_ZERO) begin
                        result_d = 32'd0;
                    end else begin
                        result_d = result_q;
                    end
                    if (bus.seq_clear) begin
                        state_d = ST_CLEAR;
                    end else if (bus.seq_len == LEN_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (bus.seq_abort) begin
                    state_d = ST_IDLE;
                end else if (remain_q == LEN_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // An aborted handshake still feeds the MAC but is not counted.
                if (bus.seq_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.op_valid) begin
                    remain_d = remain_q - LEN_ONE;
                    if (remain_q == LEN_ONE) begin
                        result_d = mac_result;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending CPU strobe bookkeeping; a reset supersedes any queued accumulate
    always_comb begin
        if (idle_free_s) begin
            pend_reset_d = 1'b0;
            pend_accum_d = 1'b0;
        end else begin
            pend_reset_d = pr_after_s | cpu_reset_accum;
            if (cpu_reset_accum) begin
                pend_accum_d = 1'b0;
            end else begin
                pend_accum_d = pa_after_s | (cpu_accumulate & ~pr_after_s);
            end
        end
    end

    // MAC steering and status outputs; reset forces a held accumulator clear
    always_comb begin
        mac_a            = cpu_a;
        mac_b            = cpu_b;
        mac_mult_enabled = cpu_mult_enabled;
        mac_add_or_sub   = cpu_add_or_sub;
        mac_reset_accum  = 1'b0;
        mac_accumulate   = 1'b0;
        op_ready_s       = 1'b0;
        result_valid_s   = 1'b0;
        seq_ready_s      = idle_free_s;
        busy_s           = (state_q != ST_IDLE) | pending_s;
        result_data_s    = result_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_free_s) begin
                    mac_reset_accum = cpu_reset_accum;
                    mac_accumulate  = cpu_accumulate & ~cpu_reset_accum;
                end else begin
                    mac_reset_accum = svc_reset_s;
                    mac_accumulate  = svc_accum_s;
                end
            end
            ST_CLEAR: begin
                mac_reset_accum = 1'b1;
            end
            ST_RUN: begin
                op_ready_s       = 1'b1;
                mac_a            = bus.op_a;
                mac_b            = bus.op_b;
                mac_mult_enabled = 1'b1;
                mac_add_or_sub   = sub_q;
                mac_accumulate   = bus.op_valid;
            end
            ST_DONE: begin
                result_valid_s = 1'b1;
            end
            default: begin
                mac_reset_accum = 1'b0;
            end
        endcase
        if (!rst_n) begin
            mac_a            = 16'd0;
            mac_b            = 16'd0;
            mac_mult_enabled = 1'b0;
            mac_add_or_sub   = 1'b0;
            mac_reset_accum  = 1'b1;
            mac_accumulate   = 1'b0;
            op_ready_s       = 1'b0;
            result_valid_s   = 1'b0;
            seq_ready_s      = 1'b0;
            busy_s           = 1'b0;
            result_data_s    = 32'd0;
        end else begin
            result_data_s = result_q;
        end
    end

    assign bus.seq_ready    = seq_ready_s;
    assign bus.op_ready     = op_ready_s;
    assign bus.result_valid = result_valid_s;
    assign bus.result_data  = result_data_s;
    assign bus.busy         = busy_s;
endmodule
